codec_stream_buffer: RTL and testbench
======================================

Name: codec_stream_buffer

Overview:
- Multi-channel, parametrised replacement for the single-sample codec output conditioner.
- Buffers up to DEPTH frames from the sample generator. Each frame holds CHANNELS samples of WIDTH bits.
- Releases one frame per codec New_Frame rising edge, with zero-latency presentation on that edge.
- Adds low-water refill requests, full/ready back-pressure, and underrun handling with a saturating counter. Sits between the synth/player core and the codec serialiser.

Parameters:
- WIDTH, 16, bits per sample.
- CHANNELS, 2, samples per frame; packed channel 0 in the LSBs.
- DEPTH, 4, FIFO depth in frames; power of two, at least 2.
- LOW_WATER, 2, request_sample is asserted while fill_level < LOW_WATER; range 1..DEPTH.
- MUTE_ON_UNDERRUN, 1, selects underrun output: 1 = output zeros, 0 = repeat the last frame.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_in  in  CHANNELS*WIDTH  frame to enqueue.
- sample_valid  in  1  producer offers sample_in this cycle.
- sample_ready  out  1  FIFO can accept a frame (not full).
- new_frame  in  1  codec frame strobe (level, may be multi-cycle).
- frame_tick  out  1  one-cycle pulse on new_frame rising edge.
- request_sample  out  1  refill request, level-based.
- valid_sample  out  CHANNELS*WIDTH  frame presented to the codec.
- fill_level  out  $clog2(DEPTH+1)  frames currently stored.
- underrun  out  1  one-cycle pulse when a tick finds the FIFO empty.
- underrun_count  out  16  saturating count of underruns.
- clear_underrun  in  1  synchronous clear of underrun_count.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fill_level=0, new_frame history=0, current frame=0, underrun_count=0. Reset values of outputs:
  - valid_sample=0
  - frame_tick=0
  - underrun=0
  - sample_ready=1
  - request_sample=1
- Edge detect: frame_tick = new_frame & ~prev. prev is a registered copy of new_frame. A new_frame already high at reset release produces one tick.
- Write: the handshake is sample_valid & sample_ready. sample_ready = (fill_level != DEPTH), taken from registered state only, with no same-cycle pop credit.
- Tick with FIFO non-empty:
  - valid_sample equals the FIFO head combinationally in the tick cycle.
  - The head is registered into current and popped at the clock edge.
- Tick with FIFO empty:
  - underrun pulses for one cycle.
  - underrun_count increments, saturating at 16'hFFFF.
  - If MUTE_ON_UNDERRUN=1, valid_sample=0 in the tick cycle and current<=0.
  - Otherwise valid_sample=current and current is unchanged.
- Outside tick cycles, valid_sample=current. It never changes while new_frame stays high after its rising edge.
- Simultaneous write and tick:
  - Non-empty: push and pop both occur and fill_level is unchanged.
  - Empty: the frame is written, the tick underruns, and there is no bypass. fill_level goes 0->1.
- Full and tick in the same cycle: the write is refused because sample_ready=0; the pop proceeds.
- Pointers are log2(DEPTH) bits and wrap naturally. fill_level is a separate up/down counter.
- request_sample = (fill_level < LOW_WATER). It is combinational from registered count.
- If clear_underrun coincides with an underrun, the clear wins and the count becomes 0.

Decomposition:
- Package codec_pkg holds:
  - the sample width default and channel default;
  - the frame-width helper function (CHANNELS*WIDTH);
  - the underrun counter width constant (16).
- One sub-module, codec_frame_fifo: synchronous FIFO with push/pop, head output, count, and full/empty. It has no bypass and is parametrised by data width and DEPTH.
- Edge detect, output selection, and underrun logic stay in the top module.

Test Plan:
- Reset/fill: release reset_n, write frames 16'h1111/16'h2222, then 16'h3333/16'h4444. Required: fill_level=2, request_sample=0 (LOW_WATER=2), valid_sample=0.
- Zero-latency tick: with FIFO holding 0x2222_1111, raise new_frame for 5 cycles. Required:
  - frame_tick high exactly one cycle;
  - valid_sample=0x2222_1111 in that same cycle and held for the next 4 cycles;
  - fill_level decrements by 1.
- Full back-pressure: write 5 frames with DEPTH=4. Required: sample_ready drops after the 4th, the 5th is not stored, and fill_level=4. A tick then pops frame 1 and sample_ready returns the next cycle.
- Underrun, both modes, FIFO empty, one tick:
  - MUTE=1: valid_sample=0, underrun pulse, underrun_count=1.
  - MUTE=0: valid_sample holds the previous frame and the count increments.
- Simultaneous: tick and write in the same cycle at fill_level=2 leaves fill_level=2. Tick and write at fill_level=0 gives underrun=1, then fill_level=1. clear_underrun with an underrun gives count=0.
- Mid-operation reset: assert reset_n low while fill_level=3 and new_frame is high. Required: immediately fill_level=0, valid_sample=0, underrun_count=0. After release, a tick is generated if new_frame is still high, and it underruns.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared constants and helpers for the codec stream buffer.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package codec_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int CHANNELS_DEF     = 2;
    localparam int UNDERRUN_CNT_W   = 16;

    // Width of one packed frame; channel 0 occupies the LSBs.
    function automatic int frame_width(input int channels, input int width);
        return channels * width;
    endfunction

endpackage

// File: rtl/codec_frame_fifo.sv
// Synchronous frame FIFO with registered count and full/empty flags, no bypass.
// Latency: a pushed frame is visible on head one cycle after the push edge.
// Backpressure: push is ignored when full and pop is ignored when empty.
//
// Ports: clk/reset_n; push + push_data enqueue; pop dequeues; head is the
// oldest stored frame; count/full/empty come straight from registered state.
module codec_frame_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // Storage carries no reset; empty is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap without compare logic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/codec_stream_buffer.sv
// Multi-channel frame buffer between the synth core and the codec serialiser.
// Latency: frame head appears on valid_sample in the same cycle as the new_frame rising edge.
// Backpressure: sample_ready drops when DEPTH frames are stored; a same-cycle pop gives no credit.
//
// Ports: sample_in/sample_valid/sample_ready write side; new_frame strobe in,
// frame_tick/valid_sample out; request_sample low-water refill; fill_level;
// underrun pulse, underrun_count saturating counter, clear_underrun.
module codec_stream_buffer
    import codec_pkg::*;
#(
    parameter int WIDTH            = SAMPLE_WIDTH_DEF,
    parameter int CHANNELS         = CHANNELS_DEF,
    parameter int DEPTH            = 4,
    parameter int LOW_WATER        = 2,
    parameter int MUTE_ON_UNDERRUN = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [CHANNELS*WIDTH-1:0]    sample_in,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    input  logic                         new_frame,
    output logic                         frame_tick,
    output logic                         request_sample,
    output logic [CHANNELS*WIDTH-1:0]    valid_sample,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level,
    output logic                         underrun,
    output logic [UNDERRUN_CNT_W-1:0]    underrun_count,
    input  logic                         clear_underrun
);
    localparam int FW = frame_width(CHANNELS, WIDTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0]             LOW_WATER_C = CW'(LOW_WATER);
    localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX     = '1;

    logic          prev_frame;
    logic [FW-1:0] current;
    logic [FW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Qualified by reset_n so no tick (and no underrun) is reported while
    // reset is held; a strobe still high at release then ticks once.
    assign frame_tick     = new_frame & ~prev_frame & reset_n;
    assign sample_ready   = ~full;
    assign push           = sample_valid & sample_ready;
    assign pop            = frame_tick & ~empty;
    assign underrun       = frame_tick & empty;
    assign request_sample = (fill_level < LOW_WATER_C);

    codec_frame_fifo #(
        .DW    (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (sample_in),
        .pop       (pop),
        .head      (head),
        .count     (fill_level),
        .full      (full),
        .empty     (empty)
    );

    // Zero-latency presentation: the head is shown combinationally on the
    // tick cycle and then held from current until the next tick.
    always_comb begin
        valid_sample = current;
        if (pop) begin
            valid_sample = head;
        end else if (underrun && (MUTE_ON_UNDERRUN != 0)) begin
            valid_sample = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_frame <= 1'b0;
            current    <= '0;
        end else begin
            prev_frame <= new_frame;
            if (pop) begin
                current <= head;
            end else if (underrun && (MUTE_ON_UNDERRUN != 0)) begin
                current <= '0;
            end
        end
    end

    // Clear has priority over a coincident underrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (clear_underrun) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != CNT_MAX)) begin
            underrun_count <= underrun_count + UNDERRUN_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_codec_stream_buffer.sv
// Scoreboard bench for codec_stream_buffer: muted instance plus a repeat-last instance.
// Latency: tick-cycle outputs are checked at the falling edge of the tick cycle.
// Backpressure: sample_ready is checked around the full boundary.
module tb_codec_stream_buffer;

    typedef struct packed {
        logic [31:0] vs;
        logic        ur;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Muted instance signals
    logic        reset_n;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        new_frame;
    logic        frame_tick;
    logic        request_sample;
    logic [31:0] valid_sample;
    logic [2:0]  fill_level;
    logic        underrun;
    logic [15:0] underrun_count;
    logic        clear_underrun;

    // Repeat-last instance signals
    logic        r_reset_n;
    logic [31:0] r_sample_in;
    logic        r_sample_valid;
    logic        r_sample_ready;
    logic        r_new_frame;
    logic        r_frame_tick;
    logic        r_request_sample;
    logic [31:0] r_valid_sample;
    logic [2:0]  r_fill_level;
    logic        r_underrun;
    logic [15:0] r_underrun_count;
    logic        r_clear_underrun;
    logic        r_done = 1'b0;

    exp_t q[$];
    exp_t rq[$];

    codec_stream_buffer #(
        .WIDTH(16), .CHANNELS(2), .DEPTH(4), .LOW_WATER(2), .MUTE_ON_UNDERRUN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .new_frame(new_frame), .frame_tick(frame_tick),
        .request_sample(request_sample), .valid_sample(valid_sample),
        .fill_level(fill_level), .underrun(underrun),
        .underrun_count(underrun_count), .clear_underrun(clear_underrun)
    );

    codec_stream_buffer #(
        .WIDTH(16), .CHANNELS(2), .DEPTH(4), .LOW_WATER(2), .MUTE_ON_UNDERRUN(0)
    ) dut_r (
        .clk(clk), .reset_n(r_reset_n), .sample_in(r_sample_in),
        .sample_valid(r_sample_valid), .sample_ready(r_sample_ready),
        .new_frame(r_new_frame), .frame_tick(r_frame_tick),
        .request_sample(r_request_sample), .valid_sample(r_valid_sample),
        .fill_level(r_fill_level), .underrun(r_underrun),
        .underrun_count(r_underrun_count), .clear_underrun(r_clear_underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] vs, input logic ur);
        q.push_back('{vs: vs, ur: ur});
        new_frame = 1'b1;
        cyc();
        new_frame = 1'b0;
        cyc();
    endtask

    task automatic r_pulse(input logic [31:0] vs, input logic ur);
        rq.push_back('{vs: vs, ur: ur});
        r_new_frame = 1'b1;
        cyc();
        r_new_frame = 1'b0;
        cyc();
    endtask

    // Monitors: every tick the DUT shows must match the next queued expectation.
    always @(negedge clk) begin
        if (frame_tick) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("tick_valid_sample", valid_sample, e.vs);
                chk("tick_underrun", {31'd0, underrun}, {31'd0, e.ur});
            end
        end else if (underrun) begin
            chk("underrun_without_tick", {31'd0, frame_tick}, 32'd1);
        end
    end

    always @(negedge clk) begin
        if (r_frame_tick) begin
            if (rq.size() == 0) begin
                chk("r_unexpected_tick", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = rq.pop_front();
                chk("r_tick_valid_sample", r_valid_sample, e.vs);
                chk("r_tick_underrun", {31'd0, r_underrun}, {31'd0, e.ur});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Repeat-last-frame instance
    initial begin
        r_reset_n = 1'b0; r_sample_in = '0; r_sample_valid = 1'b0;
        r_new_frame = 1'b0; r_clear_underrun = 1'b0;
        repeat (3) cyc();
        r_reset_n = 1'b1;
        r_sample_valid = 1'b1; r_sample_in = 32'h1234_5678;
        cyc();
        r_sample_valid = 1'b0;
        r_pulse(32'h1234_5678, 1'b0);
        r_pulse(32'h1234_5678, 1'b1);
        chk("r_count_after_underrun", {16'd0, r_underrun_count}, 32'd1);
        chk("r_hold_last_frame", r_valid_sample, 32'h1234_5678);
        chk("r_fill_empty", {29'd0, r_fill_level}, 32'd0);
        r_done = 1'b1;
    end

    logic [31:0] f [5];

    initial begin
        reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
        new_frame = 1'b0; clear_underrun = 1'b0;
        for (int i = 0; i < 5; i++) f[i] = 32'hA000_0000 | i;
        repeat (3) cyc();
        chk("rst_fill_level", {29'd0, fill_level}, 32'd0);
        chk("rst_valid_sample", valid_sample, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
        chk("rst_request_sample", {31'd0, request_sample}, 32'd1);
        chk("rst_underrun_count", {16'd0, underrun_count}, 32'd0);
        reset_n = 1'b1;

        // Fill with two frames
        sample_valid = 1'b1; sample_in = 32'h2222_1111;
        cyc();
        sample_in = 32'h4444_3333;
        cyc();
        sample_valid = 1'b0;
        chk("fill_two", {29'd0, fill_level}, 32'd2);
        chk("request_at_low_water", {31'd0, request_sample}, 32'd0);
        chk("valid_before_tick", valid_sample, 32'd0);

        // Zero-latency tick with a 5-cycle strobe
        q.push_back('{vs: 32'h2222_1111, ur: 1'b0});
        new_frame = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_frame_tick", {31'd0, frame_tick}, (i == 0) ? 32'd1 : 32'd0);
            chk("hold_valid_sample", valid_sample, 32'h2222_1111);
            cyc();
        end
        new_frame = 1'b0;
        chk("fill_after_tick", {29'd0, fill_level}, 32'd1);
        cyc();
        pulse(32'h4444_3333, 1'b0);
        chk("request_when_empty", {31'd0, request_sample}, 32'd1);

        // Full back-pressure: five offers, four accepted
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_in = f[i];
            @(negedge clk);
            chk("ready_while_filling", {31'd0, sample_ready}, (i < 4) ? 32'd1 : 32'd0);
            cyc();
        end
        chk("fill_full", {29'd0, fill_level}, 32'd4);
        // Tick while full with the fifth frame still offered
        q.push_back('{vs: f[0], ur: 1'b0});
        new_frame = 1'b1;
        @(negedge clk);
        chk("ready_full_tick", {31'd0, sample_ready}, 32'd0);
        cyc();
        new_frame = 1'b0; sample_valid = 1'b0;
        chk("fill_after_full_tick", {29'd0, fill_level}, 32'd3);
        chk("ready_after_pop", {31'd0, sample_ready}, 32'd1);
        cyc();
        pulse(f[1], 1'b0);

        // Tick and write together at fill_level 2
        q.push_back('{vs: f[2], ur: 1'b0});
        new_frame = 1'b1; sample_valid = 1'b1; sample_in = 32'h5555_6666;
        cyc();
        new_frame = 1'b0; sample_valid = 1'b0;
        chk("fill_push_pop", {29'd0, fill_level}, 32'd2);
        cyc();
        pulse(f[3], 1'b0);
        pulse(32'h5555_6666, 1'b0);

        // Muted underrun
        pulse(32'd0, 1'b1);
        chk("count_first_underrun", {16'd0, underrun_count}, 32'd1);
        chk("muted_valid_after", valid_sample, 32'd0);

        // Tick and write together on an empty FIFO: no bypass
        q.push_back('{vs: 32'd0, ur: 1'b1});
        new_frame = 1'b1; sample_valid = 1'b1; sample_in = 32'h7777_8888;
        cyc();
        new_frame = 1'b0; sample_valid = 1'b0;
        chk("fill_empty_write_tick", {29'd0, fill_level}, 32'd1);
        chk("count_second_underrun", {16'd0, underrun_count}, 32'd2);
        cyc();
        pulse(32'h7777_8888, 1'b0);

        // Clear wins over a coincident underrun
        q.push_back('{vs: 32'd0, ur: 1'b1});
        new_frame = 1'b1; clear_underrun = 1'b1;
        cyc();
        new_frame = 1'b0; clear_underrun = 1'b0;
        chk("clear_wins", {16'd0, underrun_count}, 32'd0);
        cyc();
        pulse(32'd0, 1'b1);

        // Mid-operation reset with the strobe held high
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_in = 32'hC0DE_0000 | i;
            cyc();
        end
        sample_valid = 1'b0;
        q.push_back('{vs: 32'hC0DE_0000, ur: 1'b0});
        new_frame = 1'b1;
        cyc();
        chk("fill_before_reset", {29'd0, fill_level}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk("midrst_fill_level", {29'd0, fill_level}, 32'd0);
        chk("midrst_valid_sample", valid_sample, 32'd0);
        chk("midrst_underrun_count", {16'd0, underrun_count}, 32'd0);
        chk("midrst_frame_tick", {31'd0, frame_tick}, 32'd0);
        repeat (2) cyc();
        q.push_back('{vs: 32'd0, ur: 1'b1});
        reset_n = 1'b1;
        cyc();
        new_frame = 1'b0;
        chk("post_reset_count", {16'd0, underrun_count}, 32'd1);
        chk("post_reset_fill", {29'd0, fill_level}, 32'd0);
        cyc();

        for (int i = 0; i < 50 && !r_done; i++) cyc();
        chk("r_sequence_done", {31'd0, r_done}, 32'd1);
        chk("queue_drained", q.size(), 32'd0);
        chk("r_queue_drained", rq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
